// File: rtl/hash_round_sequencer.sv
// Round/step sequencer for the hash core: walks ROUNDS x STEPS message steps
// per block, then an optional FINAL_STEPS finalization pass, one step per enabled cycle.
module hash_round_sequencer #(
    parameter int STEPS       = 8,
    parameter int ROUNDS      = 36,
    parameter int FINAL_STEPS = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        block_last,
    input  logic                                        step_en,
    input  logic                                        abort,
    output logic                                        ready,
    output logic                                        busy,
    output logic [1:0]                                  phase,
    output logic [$clog2(STEPS)-1:0]                    step_idx,
    output logic [(($clog2(ROUNDS) > 1) ? $clog2(ROUNDS) : 1)-1:0] round_idx,
    output logic                                        round_done,
    output logic                                        final_done
);

    localparam int SW = $clog2(STEPS);
    localparam int RW = ($clog2(ROUNDS) > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS - 1);
    localparam logic [SW-1:0] FINAL_LAST = SW'(FINAL_STEPS - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

    if (STEPS < 2) begin : g_bad_steps
        $error("hash_round_sequencer: STEPS must be >= 2");
    end
    if (ROUNDS < 1) begin : g_bad_rounds
        $error("hash_round_sequencer: ROUNDS must be >= 1");
    end
    if (FINAL_STEPS < 1 || FINAL_STEPS > STEPS) begin : g_bad_final
        $error("hash_round_sequencer: FINAL_STEPS must be in 1..STEPS");
    end

    // Encodings double as the phase output value.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [RW-1:0] round_q, round_d;
    logic          last_q, last_d;
    logic          round_done_q, round_done_d;
    logic          final_done_q, final_done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            round_q      <= '0;
            last_q       <= 1'b0;
            round_done_q <= 1'b0;
            final_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            round_q      <= round_d;
            last_q       <= last_d;
            round_done_q <= round_done_d;
            final_done_q <= final_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        round_d      = round_q;
        last_d       = last_q;
        round_done_d = 1'b0;
        final_done_d = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            step_d  = '0;
            round_d = '0;
            last_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_ROUND;
                        step_d  = '0;
                        round_d = '0;
                        last_d  = block_last;
                    end
                end
                S_ROUND: begin
                    if (step_en) begin
                        if (step_q != STEP_LAST) begin
                            step_d = step_q + 1'b1;
                        end else if (round_q != ROUND_LAST) begin
                            step_d  = '0;
                            round_d = round_q + 1'b1;
                        end else begin
                            // Terminal step: pulse lands in the first cycle of the next state.
                            step_d       = '0;
                            round_d      = '0;
                            round_done_d = 1'b1;
                            state_d      = last_q ? S_FINAL : S_IDLE;
                        end
                    end
                end
                S_FINAL: begin
                    if (step_en) begin
                        if (step_q != FINAL_LAST) begin
                            step_d = step_q + 1'b1;
                        end else begin
                            step_d       = '0;
                            last_d       = 1'b0;
                            final_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    round_d = '0;
                    last_d  = 1'b0;
                end
            endcase
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign busy       = (state_q == S_ROUND) || (state_q == S_FINAL);
    assign phase      = state_q;
    assign step_idx   = step_q;
    assign round_idx  = round_q;
    assign round_done = round_done_q;
    assign final_done = final_done_q;

endmodule

// File: tb/tb_hash_round_sequencer.sv
// Bench for hash_round_sequencer: a default-sized and a small instance share
// stimulus; each is compared every cycle against a linear-position model.
module tb_hash_round_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic block_last = 1'b0;
    logic step_en = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    logic       ready_b, busy_b, rd_b, fd_b;
    logic [1:0] phase_b;
    logic [2:0] step_b;
    logic [5:0] round_b;

    logic       ready_s, busy_s, rd_s, fd_s;
    logic [1:0] phase_s;
    logic [1:0] step_s;
    logic [1:0] round_s;

    hash_round_sequencer dut_big (
        .clk(clk), .reset(reset), .start(start), .block_last(block_last),
        .step_en(step_en), .abort(abort), .ready(ready_b), .busy(busy_b),
        .phase(phase_b), .step_idx(step_b), .round_idx(round_b),
        .round_done(rd_b), .final_done(fd_b)
    );

    hash_round_sequencer #(.STEPS(4), .ROUNDS(3), .FINAL_STEPS(2)) dut_small (
        .clk(clk), .reset(reset), .start(start), .block_last(block_last),
        .step_en(step_en), .abort(abort), .ready(ready_s), .busy(busy_s),
        .phase(phase_s), .step_idx(step_s), .round_idx(round_s),
        .round_done(rd_s), .final_done(fd_s)
    );

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle / 1 rounds / 2 finalization; pos counts enabled steps in the current pass.
    typedef struct {
        int mode;
        int pos;
        bit last;
        bit rd;
        bit fd;
    } ms_t;

    function automatic ms_t mstep(input ms_t s, input int S, input int R, input int F,
                                  input bit st, input bit bl, input bit en, input bit ab);
        ms_t n = s;
        n.rd = 1'b0;
        n.fd = 1'b0;
        if (ab) begin
            n.mode = 0; n.pos = 0; n.last = 1'b0;
        end else if (s.mode == 0) begin
            if (st) begin
                n.mode = 1; n.pos = 0; n.last = bl;
            end
        end else if (en) begin
            n.pos = s.pos + 1;
            if (s.mode == 1 && n.pos == R * S) begin
                n.rd = 1'b1; n.pos = 0; n.mode = s.last ? 2 : 0;
            end else if (s.mode == 2 && n.pos == F) begin
                n.fd = 1'b1; n.pos = 0; n.mode = 0; n.last = 1'b0;
            end
        end
        return n;
    endfunction

    ms_t mb = '{0, 0, 1'b0, 1'b0, 1'b0};
    ms_t ms = '{0, 0, 1'b0, 1'b0, 1'b0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mb <= '{0, 0, 1'b0, 1'b0, 1'b0};
            ms <= '{0, 0, 1'b0, 1'b0, 1'b0};
        end else begin
            mb <= mstep(mb, 8, 36, 8, start, block_last, step_en, abort);
            ms <= mstep(ms, 4, 3, 2, start, block_last, step_en, abort);
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("b_ready", ready_b, mb.mode == 0);
            chk("b_busy", busy_b, mb.mode != 0);
            chk("b_phase", phase_b, mb.mode);
            chk("b_step", step_b, (mb.mode == 1) ? mb.pos % 8 : mb.pos);
            chk("b_round", round_b, (mb.mode == 1) ? mb.pos / 8 : 0);
            chk("b_round_done", rd_b, mb.rd);
            chk("b_final_done", fd_b, mb.fd);
            chk("s_ready", ready_s, ms.mode == 0);
            chk("s_busy", busy_s, ms.mode != 0);
            chk("s_phase", phase_s, ms.mode);
            chk("s_step", step_s, (ms.mode == 1) ? ms.pos % 4 : ms.pos);
            chk("s_round", round_s, (ms.mode == 1) ? ms.pos / 4 : 0);
            chk("s_round_done", rd_s, ms.rd);
            chk("s_final_done", fd_s, ms.fd);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int ens;
        bit fd_seen;

        cyc(); cyc();
        chk("reset_ready", ready_b, 1);
        chk("reset_phase", phase_b, 0);
        reset = 1'b0;
        checking = 1'b1;
        cyc();

        // 1: non-last block, continuous enable
        start = 1'b1; block_last = 1'b0; step_en = 1'b1;
        cyc();
        start = 1'b0;
        n = 1; fd_seen = 1'b0;
        while (rd_b !== 1'b1 && n < 400) begin fd_seen |= fd_b; cyc(); n++; end
        chk("t1_rd_cycle", n, 289);
        chk("t1_phase", phase_b, 0);
        repeat (12) begin fd_seen |= fd_b; cyc(); end
        chk("t1_no_final_done", fd_seen, 0);

        // 2: last block with finalization
        start = 1'b1; block_last = 1'b1;
        cyc();
        start = 1'b0;
        n = 1;
        while (rd_b !== 1'b1 && n < 400) begin cyc(); n++; end
        chk("t2_rd_cycle", n, 289);
        chk("t2_rd_phase", phase_b, 2);
        while (fd_b !== 1'b1 && n < 400) begin cyc(); n++; end
        chk("t2_fd_cycle", n, 297);
        chk("t2_fd_step", step_b, 0);
        chk("t2_fd_ready", ready_b, 1);
        repeat (4) cyc();

        // 3: step_en toggling every cycle
        start = 1'b1; block_last = 1'b0; step_en = 1'b1;
        cyc();
        start = 1'b0;
        n = 1; ens = 0;
        while (rd_b !== 1'b1 && n < 1000) begin
            if (step_en) ens++;
            cyc(); n++;
            step_en = ~step_en;
        end
        chk("t3_enabled_steps", ens, 288);
        chk("t3_total_cycles", n, 576);
        step_en = 1'b1;
        repeat (12) cyc();

        // 4: abort mid-block, then abort+start in idle
        start = 1'b1; block_last = 1'b1;
        cyc();
        start = 1'b0;
        repeat (139) cyc();
        chk("t4_round_at_abort", round_b, 17);
        chk("t4_step_at_abort", step_b, 3);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t4_phase", phase_b, 0);
        chk("t4_step", step_b, 0);
        chk("t4_round", round_b, 0);
        chk("t4_rd", rd_b, 0);
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("t4_start_dropped", phase_b, 0);
        repeat (4) cyc();

        // 5: small instance, zero-gap chaining into a last block
        start = 1'b1; block_last = 1'b0;
        cyc();
        start = 1'b0;
        n = 1;
        while (rd_s !== 1'b1 && n < 100) begin cyc(); n++; end
        chk("t5_rd_cycle", n, 13);
        chk("t5_ready_in_rd", ready_s, 1);
        start = 1'b1; block_last = 1'b1;
        cyc();
        start = 1'b0;
        chk("t5_no_gap_phase", phase_s, 1);
        n = 1;
        while (fd_s !== 1'b1 && n < 100) begin cyc(); n++; end
        chk("t5_fd_cycle", n, 15);
        repeat (300) cyc();

        // 6: async reset mid-finalization
        start = 1'b1; block_last = 1'b1;
        cyc();
        start = 1'b0;
        repeat (293) cyc();
        chk("t6_phase_pre", phase_b, 2);
        chk("t6_step_pre", step_b, 5);
        #2 reset = 1'b1;
        #1;
        chk("t6_ready", ready_b, 1);
        chk("t6_busy", busy_b, 0);
        chk("t6_phase", phase_b, 0);
        chk("t6_step", step_b, 0);
        chk("t6_round", round_b, 0);
        chk("t6_fd", fd_b, 0);
        start = 1'b1;
        cyc(); cyc();
        chk("t6_start_in_reset", phase_b, 0);
        reset = 1'b0; start = 1'b0;
        cyc();

        // Random traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 99) < 30);
            block_last = $urandom_range(0, 1);
            step_en    = ($urandom_range(0, 99) < 85);
            abort      = ($urandom_range(0, 999) < 8);
            reset      = ($urandom_range(0, 999) < 2);
            cyc();
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hash_round_sequencer.md
Name: hash_round_sequencer

Overview:
- Parametrised successor to the hash core's round/step counter.
- Sequences per-block message rounds (ROUNDS × STEPS) and an optional finalization pass (FINAL_STEPS), one step per enabled cycle.
- Adds a start/ready handshake, a step-enable stall, abort, and per-block "last" chaining with registered one-cycle done pulses.
- Sits between the top-level hash FSM and the datapath; step_idx drives the H[i]/C[i] index.

Parameters:
- STEPS, 8, steps per round (≥2).
- ROUNDS, 36, rounds per message block (≥1).
- FINAL_STEPS, 8, steps in the finalization pass (1..STEPS; elaboration error otherwise).
- SW, $clog2(STEPS), step index width (derived, not overridable).
- RW, max(1,$clog2(ROUNDS)), round index width (derived, not overridable).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a block; accepted only when ready=1
- block_last  in  1  sampled with accepted start; 1 = run finalization after this block
- step_en  in  1  advance one step this cycle; 0 = stall, all state held
- abort  in  1  synchronous abort to IDLE, highest priority after reset
- ready  out  1  1 in IDLE
- busy  out  1  1 in ROUND or FINAL
- phase  out  2  0=IDLE, 1=ROUND, 2=FINAL (3 never driven)
- step_idx  out  SW  current step index
- round_idx  out  RW  current round index
- round_done  out  1  one-cycle pulse: message rounds of a block complete
- final_done  out  1  one-cycle pulse: finalization complete

Behaviour:
- Reset (async, any time, including mid-block): state=IDLE, step_idx=0, round_idx=0, last_q=0, round_done=0, final_done=0, ready=1, busy=0, phase=0.
- Priority each cycle: reset > abort > start/step logic.
- IDLE:
  - start=1 → next cycle ROUND, step_idx=0, round_idx=0, last_q<=block_last.
  - step_en is ignored.
- ROUND, step_en=1:
  - step_idx<STEPS-1 → step_idx+1.
  - Otherwise step_idx→0 and round_idx+1, unless round_idx=ROUNDS-1.
  - At step_idx=STEPS-1 and round_idx=ROUNDS-1: next cycle round_done=1, round_idx=0, step_idx=0. State becomes FINAL if last_q=1, else IDLE.
- ROUND or FINAL, step_en=0: all counters and state held; no pulses.
- FINAL, step_en=1:
  - step_idx<FINAL_STEPS-1 → +1; round_idx stays 0.
  - At FINAL_STEPS-1: next cycle final_done=1, state=IDLE, step_idx=0, last_q=0.
- Pulses are registered, high for exactly one cycle, and coincide with the first cycle of the new state.
- Latency: a non-last block takes ROUNDS×STEPS enabled cycles, then round_done. A last block adds FINAL_STEPS enabled cycles, then final_done.
- Back-to-back blocks: ready=1 in the round_done cycle of a non-last block, so start is accepted there (zero-gap chaining).
- start while busy: ignored, no effect on counters or last_q.
- abort:
  - In ROUND/FINAL → next cycle IDLE, counters 0, last_q=0, no round_done/final_done.
  - abort+start in IDLE → start dropped.
  - abort in the cycle of a terminal step → abort wins; no pulse.
- Counters never exceed their terminal values; no wrap beyond ROUNDS-1 or FINAL_STEPS-1.

Test Plan:
1. Defaults, start with block_last=0, step_en held 1 → round_done high exactly on cycle 289 after start acceptance, phase=0, final_done never asserted.
2. Defaults, block_last=1, step_en=1 → round_done at cycle 289 with phase=2, then final_done at cycle 297 with step_idx=0, ready=1.
3. step_en toggling 1/0 every cycle, defaults, non-last block → counters hold on 0-cycles; round_done after exactly 288 enabled cycles (576 total).
4. abort at round_idx=17, step_idx=3 → next cycle IDLE, counters 0, no pulses. Then a start in the same cycle as a second abort is dropped.
5. STEPS=4, ROUNDS=3, FINAL_STEPS=2, two blocks (second last), start reasserted in the round_done cycle → second block runs with no idle gap, final_done 14 enabled cycles after second start.
6. Async reset asserted mid-FINAL at step_idx=5 (between clock edges) → outputs immediately at reset values; start ignored while reset is high.
